// File: rtl/button_pio_debounced_pkg.sv
// button_pio_pkg: constants shared by the debounced button PIO.
//   - Avalon register word offsets (3-bit address space)
//   - Default parameter values for the top level
package button_pio_pkg;

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_RAW   = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_CAP   = 3'd3;
    localparam logic [2:0] ADDR_RISE  = 3'd4;
    localparam logic [2:0] ADDR_FALL  = 3'd5;
    localparam logic [2:0] ADDR_DEBTH = 3'd6;

    localparam int unsigned DEF_WIDTH       = 5;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 20;
    localparam int unsigned DEF_DEBOUNCE    = 50000;

endpackage

// File: rtl/button_pio_debounced_channel.sv
// pio_debounce_channel: one input channel of the debounced PIO.
//   Synchroniser chain, debounce counter, debounced state and its
//   one-cycle delayed copy for edge detection.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   in_raw_i      - asynchronous raw input
//   th_i          - debounce threshold, already forced non-zero by caller
//   sync_o        - synchronised input (last synchroniser stage)
//   db_o          - debounced state
//   rise_raw_o    - debounced 0->1 transition, before enable masking
//   fall_raw_o    - debounced 1->0 transition, before enable masking
module pio_debounce_channel #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 20,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_raw_i,
    input  logic [CNT_W-1:0] th_i,
    output logic             sync_o,
    output logic             db_o,
    output logic             rise_raw_o,
    output logic             fall_raw_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   db_d1_q;
    logic [CNT_W:0]         cnt_inc;

    assign sync_o = sync_q[SYNC_STAGES-1];

    // One extra bit so cnt+1 cannot wrap before the >= compare.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync_o == db_q) begin
            cnt_d = '0;
        end else if (cnt_inc >= {1'b0, th_i}) begin
            db_d  = sync_o;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            cnt_q   <= '0;
            db_q    <= RST_VAL;
            db_d1_q <= RST_VAL;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_raw_i};
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            db_d1_q <= db_q;
        end
    end

    assign db_o       = db_q;
    assign rise_raw_o =  db_q & ~db_d1_q;
    assign fall_raw_o = ~db_q &  db_d1_q;

endmodule

// File: rtl/button_pio_debounced.sv
// button_pio_debounced: Avalon-MM input PIO with synchroniser, programmable
// debounce, per-bit rise/fall edge enables, W1C edge capture and irq.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   address      - register word address (see button_pio_pkg offsets)
//   chipselect   - slave select
//   write_n      - active-low write strobe
//   writedata    - write data
//   readdata     - registered read data, 1-cycle latency
//   in_port      - asynchronous raw inputs
//   irq          - active-high interrupt, |(EDGE_CAPTURE & IRQ_MASK)
module button_pio_debounced
    import button_pio_pkg::*;
#(
    parameter int unsigned       WIDTH            = DEF_WIDTH,
    parameter int unsigned       SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int unsigned       CNT_W            = DEF_CNT_W,
    parameter int unsigned       DEBOUNCE_DEFAULT = DEF_DEBOUNCE,
    parameter logic [WIDTH-1:0]  IN_RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic             wr;
    logic [CNT_W-1:0] th;
    logic [WIDTH-1:0] sync, db, rise_raw, fall_raw, ev, clr;

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [CNT_W-1:0] debth_q, debth_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign th           = (debth_q == '0) ? CNT_W'(1) : debth_q;
    assign unused_wdata = ^writedata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        pio_debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .RST_VAL     (IN_RESET_VAL[g])
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_raw_i   (in_port[g]),
            .th_i       (th),
            .sync_o     (sync[g]),
            .db_o       (db[g]),
            .rise_raw_o (rise_raw[g]),
            .fall_raw_o (fall_raw[g])
        );
    end

    assign ev  = (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
    assign clr = (wr && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        debth_d   = debth_q;
        // New events are OR'd in after the clear so a same-cycle set wins.
        cap_d     = (cap_q & ~clr) | ev;
        if (wr) begin
            unique case (address)
                ADDR_MASK:  mask_d    = writedata[WIDTH-1:0];
                ADDR_RISE:  rise_en_d = writedata[WIDTH-1:0];
                ADDR_FALL:  fall_en_d = writedata[WIDTH-1:0];
                ADDR_DEBTH: debth_d   = writedata[CNT_W-1:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA:  readdata_d[WIDTH-1:0] = db;
            ADDR_RAW:   readdata_d[WIDTH-1:0] = sync;
            ADDR_MASK:  readdata_d[WIDTH-1:0] = mask_q;
            ADDR_CAP:   readdata_d[WIDTH-1:0] = cap_q;
            ADDR_RISE:  readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL:  readdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_DEBTH: readdata_d[CNT_W-1:0] = debth_q;
            default:    readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            debth_q    <= CNT_W'(DEBOUNCE_DEFAULT);
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            debth_q    <= debth_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_button_pio_debounced.sv
// Directed bench for button_pio_debounced (WIDTH=5, SYNC_STAGES=2,
// DEBOUNCE_DEFAULT=4, IN_RESET_VAL=0).
module tb_button_pio_debounced;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  in_port;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] rdat;
    logic [31:0] exp_rst [8];

    always #5 clk = ~clk;

    button_pio_debounced #(
        .WIDTH            (5),
        .SYNC_STAGES      (2),
        .CNT_W            (20),
        .DEBOUNCE_DEFAULT (4),
        .IN_RESET_VAL     (5'b00000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick();
        d       = readdata;
        address = 3'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        exp_rst    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1F, 32'h0, 32'h4, 32'h0};

        // Reset values
        tick();
        chk("rst_readdata", readdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), rdat);
            chk($sformatf("rst_reg%0d", i), rdat, exp_rst[i]);
        end

        // Glitch of 3 cycles on bit0 must be rejected
        in_port = 5'h01;
        repeat (3) tick();
        in_port = 5'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch_data", readdata, 32'h0);
        end
        rd(3'd3, rdat);
        chk("glitch_cap", rdat, 32'h0);

        // Stable press: db updates on edge 6, readdata shows it on edge 7
        in_port = 5'h01;
        repeat (6) tick();
        chk("lat_pre", readdata, 32'h0);
        tick();
        chk("lat_data", readdata, 32'h1);
        rd(3'd3, rdat);
        chk("press_cap", rdat, 32'h1);
        rd(3'd1, rdat);
        chk("raw", rdat, 32'h1);
        chk("irq_masked", {31'b0, irq}, 32'h0);

        // Falling-only mode on bit2
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h4);
        wr(3'd3, 32'h1);
        rd(3'd3, rdat);
        chk("w1c_bit0", rdat, 32'h0);
        in_port = 5'h05;
        repeat (10) tick();
        rd(3'd3, rdat);
        chk("fall_press_cap", rdat, 32'h0);
        rd(3'd0, rdat);
        chk("fall_press_data", rdat, 32'h5);
        in_port = 5'h01;
        repeat (10) tick();
        rd(3'd3, rdat);
        chk("fall_release_cap", rdat, 32'h4);

        // Build cap=0x05 via bit0 fall, then W1C and irq masking
        wr(3'd5, 32'h5);
        in_port = 5'h00;
        repeat (10) tick();
        rd(3'd3, rdat);
        chk("cap_05", rdat, 32'h5);
        wr(3'd2, 32'h4);
        chk("irq_on", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h1);
        rd(3'd3, rdat);
        chk("w1c_keep4", rdat, 32'h4);
        chk("irq_still", {31'b0, irq}, 32'h1);
        wr(3'd2, 32'h0);
        chk("irq_unmask_drop", {31'b0, irq}, 32'h0);
        wr(3'd2, 32'h4);
        chk("irq_remask_raise", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h1F);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        wr(3'd2, 32'h0);

        // Clear of bit1 in the same cycle its rise is captured: set wins
        wr(3'd4, 32'h2);
        in_port = 5'h02;
        repeat (6) tick();
        wr(3'd3, 32'h2);
        rd(3'd3, rdat);
        chk("set_wins", rdat, 32'h2);

        // Reset in the middle of bit3 debounce (cnt=3)
        wr(3'd4, 32'h1F);
        wr(3'd3, 32'h1F);
        in_port = 5'h0A;
        repeat (5) tick();
        reset_n = 1'b0;
        in_port = 5'h00;
        #1;
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        rd(3'd0, rdat);
        chk("midrst_data", rdat, 32'h0);
        rd(3'd3, rdat);
        chk("midrst_cap", rdat, 32'h0);
        rd(3'd6, rdat);
        chk("midrst_th", rdat, 32'h4);

        // DEB_TH=0 behaves as th=1: a 1-cycle pulse passes
        wr(3'd6, 32'h0);
        rd(3'd6, rdat);
        chk("th_zero", rdat, 32'h0);
        address = 3'd0;
        in_port = 5'h08;
        tick();
        in_port = 5'h00;
        repeat (3) tick();
        chk("pulse_data", readdata, 32'h8);
        tick();
        chk("pulse_gone", readdata, 32'h0);
        rd(3'd3, rdat);
        chk("pulse_cap", rdat, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
